// File: rtl/gemm_sched_pkg.sv
// Shared types for the GEMM tile scheduler: FSM states, latched command,
// and default field widths.
package gemm_sched_pkg;

  localparam int CNT_W    = 4;
  localparam int AW       = 8;
  localparam int ISSUED_W = 2*CNT_W + CNT_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_ADV   = 3'd3,
    S_FIN   = 3'd4
  } state_e;

  typedef struct packed {
    logic [CNT_W-1:0] m_tiles;
    logic [CNT_W-1:0] n_tiles;
    logic [CNT_W-1:0] k_tiles;
    logic [AW-1:0]    base_a;
    logic [AW-1:0]    base_b;
    logic [AW-1:0]    base_c;
  } cmd_t;

endpackage

// File: rtl/gemm_tile_addr_gen.sv
// Per-tile buffer base addresses; all sums wrap modulo 2^ADDR_WIDTH.
module gemm_tile_addr_gen
  import gemm_sched_pkg::*;
#(
  parameter int N          = 4,
  parameter int ADDR_WIDTH = AW,
  parameter int TILE_W     = CNT_W
) (
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
  input  logic [ADDR_WIDTH-1:0] base_c,
  input  logic [TILE_W-1:0]     n_tiles,
  input  logic [TILE_W-1:0]     k_tiles,
  input  logic [TILE_W-1:0]     m_idx,
  input  logic [TILE_W-1:0]     n_idx,
  input  logic [TILE_W-1:0]     k_idx,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [ADDR_WIDTH-1:0] addr_c
);

  localparam logic [ADDR_WIDTH-1:0] ROWS = ADDR_WIDTH'(N);

  function automatic logic [ADDR_WIDTH-1:0] ext(
    input logic [TILE_W-1:0] v
  );
    return ADDR_WIDTH'(v);
  endfunction

  assign addr_a = base_a
    + (ext(m_idx) * ext(k_tiles) + ext(k_idx)) * ROWS;
  assign addr_b = base_b
    + (ext(k_idx) * ext(n_tiles) + ext(n_idx)) * ROWS;
  assign addr_c = base_c
    + (ext(m_idx) * ext(n_tiles) + ext(n_idx)) * ROWS;

endmodule

// File: rtl/gemm_tile_scheduler.sv
// Walks an M x N x K tile grid (k innermost) over one GEMM core.
// Optional GEMM_SCHED_PERF_EN adds a saturating busy-cycle counter.
module gemm_tile_scheduler
  import gemm_sched_pkg::*;
#(
  parameter int N          = 4,
  parameter int ADDR_WIDTH = AW,
  parameter int TILE_W     = CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [TILE_W-1:0]     cmd_m_tiles,
  input  logic [TILE_W-1:0]     cmd_n_tiles,
  input  logic [TILE_W-1:0]     cmd_k_tiles,
  input  logic [ADDR_WIDTH-1:0] cmd_base_a,
  input  logic [ADDR_WIDTH-1:0] cmd_base_b,
  input  logic [ADDR_WIDTH-1:0] cmd_base_c,
  output logic                  core_start,
  input  logic                  core_done,
  output logic [ADDR_WIDTH-1:0] core_base_a,
  output logic [ADDR_WIDTH-1:0] core_base_b,
  output logic [ADDR_WIDTH-1:0] core_base_c,
  output logic                  core_accum,
  output logic                  busy,
  output logic                  done,
  output logic [ISSUED_W-1:0]   tiles_issued
`ifdef GEMM_SCHED_PERF_EN
  ,
  output logic [31:0]           perf_cycles
`endif
);

  state_e            state;
  cmd_t              cmd;
  logic [TILE_W-1:0] m_idx;
  logic [TILE_W-1:0] n_idx;
  logic [TILE_W-1:0] k_idx;
  logic              any_zero;
  logic              m_last;
  logic              n_last;
  logic              k_last;

  assign any_zero = (cmd_m_tiles == '0)
                 || (cmd_n_tiles == '0)
                 || (cmd_k_tiles == '0);

  assign m_last = m_idx == cmd.m_tiles - TILE_W'(1);
  assign n_last = n_idx == cmd.n_tiles - TILE_W'(1);
  assign k_last = k_idx == cmd.k_tiles - TILE_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cmd          <= '0;
      m_idx        <= '0;
      n_idx        <= '0;
      k_idx        <= '0;
      tiles_issued <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd <= '{
              m_tiles: cmd_m_tiles,
              n_tiles: cmd_n_tiles,
              k_tiles: cmd_k_tiles,
              base_a:  cmd_base_a,
              base_b:  cmd_base_b,
              base_c:  cmd_base_c
            };
            m_idx        <= '0;
            n_idx        <= '0;
            k_idx        <= '0;
            tiles_issued <= '0;
            state        <= any_zero ? S_FIN : S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (core_done) begin
            tiles_issued <= tiles_issued + ISSUED_W'(1);
            state        <= S_ADV;
          end
        end
        S_ADV: begin
          if (m_last && n_last && k_last) begin
            state <= S_FIN;
          end else begin
            state <= S_ISSUE;
            // k innermost, then n, then m
            if (!k_last) begin
              k_idx <= k_idx + TILE_W'(1);
            end else begin
              k_idx <= '0;
              if (!n_last) begin
                n_idx <= n_idx + TILE_W'(1);
              end else begin
                n_idx <= '0;
                m_idx <= m_idx + TILE_W'(1);
              end
            end
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready  = state == S_IDLE;
  assign busy       = state != S_IDLE;
  assign core_start = (state == S_ISSUE) || (state == S_WAIT);
  assign done       = state == S_FIN;
  assign core_accum = k_idx != '0;

  gemm_tile_addr_gen #(
    .N          (N),
    .ADDR_WIDTH (ADDR_WIDTH),
    .TILE_W     (TILE_W)
  ) u_addr (
    .base_a  (cmd.base_a),
    .base_b  (cmd.base_b),
    .base_c  (cmd.base_c),
    .n_tiles (cmd.n_tiles),
    .k_tiles (cmd.k_tiles),
    .m_idx   (m_idx),
    .n_idx   (n_idx),
    .k_idx   (k_idx),
    .addr_a  (core_base_a),
    .addr_b  (core_base_b),
    .addr_c  (core_base_c)
  );

`ifdef GEMM_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles <= '0;
    end else if (state == S_IDLE) begin
      if (cmd_valid) perf_cycles <= '0;
    end else if (perf_cycles != '1) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Scoreboard bench for gemm_tile_scheduler: stimulus queues expected
// starts/dones, a negedge monitor pops and compares them.
module tb_gemm_tile_scheduler;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int TW = 4;
  localparam int IW = 3*TW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [TW-1:0] cmd_m_tiles = '0;
  logic [TW-1:0] cmd_n_tiles = '0;
  logic [TW-1:0] cmd_k_tiles = '0;
  logic [AW-1:0] cmd_base_a = '0;
  logic [AW-1:0] cmd_base_b = '0;
  logic [AW-1:0] cmd_base_c = '0;
  logic          core_start;
  logic          core_done;
  logic [AW-1:0] core_base_a;
  logic [AW-1:0] core_base_b;
  logic [AW-1:0] core_base_c;
  logic          core_accum;
  logic          busy;
  logic          done;
  logic [IW-1:0] tiles_issued;
`ifdef GEMM_SCHED_PERF_EN
  logic [31:0]   perf_cycles;
`endif

  gemm_tile_scheduler #(
    .N          (N),
    .ADDR_WIDTH (AW),
    .TILE_W     (TW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_m_tiles  (cmd_m_tiles),
    .cmd_n_tiles  (cmd_n_tiles),
    .cmd_k_tiles  (cmd_k_tiles),
    .cmd_base_a   (cmd_base_a),
    .cmd_base_b   (cmd_base_b),
    .cmd_base_c   (cmd_base_c),
    .core_start   (core_start),
    .core_done    (core_done),
    .core_base_a  (core_base_a),
    .core_base_b  (core_base_b),
    .core_base_c  (core_base_c),
    .core_accum   (core_accum),
    .busy         (busy),
    .done         (done),
    .tiles_issued (tiles_issued)
`ifdef GEMM_SCHED_PERF_EN
    ,
    .perf_cycles  (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [AW-1:0] c;
    logic          acc;
  } start_t;

  typedef struct {
    int tiles;
    bit zero;
  } done_t;

  start_t sq[$];
  done_t  dq[$];

  task automatic push_s(input int a, input int b, input int c, input int acc);
    start_t s;
    s.a = AW'(a);
    s.b = AW'(b);
    s.c = AW'(c);
    s.acc = acc[0];
    sq.push_back(s);
  endtask

  task automatic push_d(input int tiles, input bit zero);
    done_t d;
    d.tiles = tiles;
    d.zero = zero;
    dq.push_back(d);
  endtask

  // Core model: done pulse lat cycles after start rises; dropped if idle.
  int   lat = 3;
  int   ccnt = 0;
  logic model_done = 1'b0;
  logic extra_done = 1'b0;
  logic prev_start = 1'b0;
  assign core_done = model_done | extra_done;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      model_done = 1'b0;
      if (rst || !busy) begin
        ccnt = 0;
      end else if (ccnt > 0) begin
        ccnt--;
        if (ccnt == 0) model_done = 1'b1;
      end else if (core_start && !prev_start) begin
        ccnt = lat;
      end
      prev_start = core_start;
    end
  end

  // Monitor
  int     n_starts = 0;
  int     n_done = 0;
  int     acc_cyc = 0;
  int     dn_cyc = 0;
  logic   mon_start = 1'b0;
  start_t ms;
  done_t  md;

  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (core_start && !mon_start) begin
        n_starts++;
        if (sq.size() == 0) begin
          chk("unexpected_start", 1, 0);
        end else begin
          ms = sq.pop_front();
          chk("core_base_a", int'(core_base_a), int'(ms.a));
          chk("core_base_b", int'(core_base_b), int'(ms.b));
          chk("core_base_c", int'(core_base_c), int'(ms.c));
          chk("core_accum", int'(core_accum), int'(ms.acc));
        end
      end
      if (done) begin
        n_done++;
        if (dq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          md = dq.pop_front();
          chk("tiles_issued", int'(tiles_issued), md.tiles);
          if (md.zero) chk("done_after_accept", cyc - acc_cyc, 1);
          else         chk("done_after_core_done", cyc - dn_cyc, 2);
        end
      end
      if (core_done && core_start) dn_cyc = cyc;
    end
    mon_start = core_start;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int m, input int n, input int k,
                      input int ba, input int bb, input int bc);
    int b = 0;
    while (!cmd_ready && b < 100) begin
      tick();
      b++;
    end
    chk("cmd_ready_before_send", int'(cmd_ready), 1);
    cmd_m_tiles = TW'(m);
    cmd_n_tiles = TW'(n);
    cmd_k_tiles = TW'(k);
    cmd_base_a  = AW'(ba);
    cmd_base_b  = AW'(bb);
    cmd_base_c  = AW'(bc);
    cmd_valid   = 1'b1;
    tick();
    cmd_valid   = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int b = 0;
    while (n_done < target && b < 500) begin
      tick();
      b++;
    end
    chk(name, int'(n_done >= target), 1);
  endtask

  int s0;
  int d0;
  int b;

  initial begin
    int ea[8] = '{0, 4, 0, 4, 8, 12, 8, 12};
    int eb[8] = '{0, 8, 4, 12, 0, 8, 4, 12};
    int ec[8] = '{0, 0, 4, 4, 8, 8, 12, 12};

    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_core_start", int'(core_start), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_core_accum", int'(core_accum), 0);
    chk("rst_base_a", int'(core_base_a), 0);
    chk("rst_base_b", int'(core_base_b), 0);
    chk("rst_base_c", int'(core_base_c), 0);
    chk("rst_tiles_issued", int'(tiles_issued), 0);

    // Single tile
    lat = 3;
    push_s(0, 64, 128, 0);
    push_d(1, 1'b0);
    send(1, 1, 1, 0, 64, 128);
    wait_done(1, "t111_done_seen");
    chk("t111_starts", n_starts, 1);

    // Stray core_done while idle must not count
    extra_done = 1'b1;
    tick();
    extra_done = 1'b0;
    tick();
    chk("idle_done_ignored", int'(tiles_issued), 1);
    chk("idle_busy", int'(busy), 0);

    // 2x2x2 grid, done in the cycle WAIT is entered
    lat = 1;
    for (int i = 0; i < 8; i++) push_s(ea[i], eb[i], ec[i], i % 2);
    push_d(8, 1'b0);
    send(2, 2, 2, 0, 0, 0);
    wait_done(2, "t222_done_seen");
    chk("t222_starts", n_starts, 9);

    // Zero count
    s0 = n_starts;
    push_d(0, 1'b1);
    send(1, 1, 0, 0, 0, 0);
    wait_done(3, "zero_done_seen");
    chk("zero_ready_again", int'(cmd_ready), 1);
    chk("zero_no_start", n_starts, s0);

    // Address wrap on C
    lat = 2;
    push_s(0, 0, 250, 0);
    push_s(0, 4, 254, 0);
    push_d(2, 1'b0);
    send(1, 2, 1, 0, 0, 250);
    wait_done(4, "wrap250_done_seen");
    push_s(0, 0, 254, 0);
    push_s(0, 4, 2, 0);
    push_d(2, 1'b0);
    send(1, 2, 1, 0, 0, 254);
    wait_done(5, "wrap254_done_seen");

    // Reset during WAIT of tile 3 of 8
    lat = 4;
    push_s(0, 0, 0, 0);
    push_s(4, 8, 0, 1);
    push_s(0, 4, 4, 0);
    s0 = n_starts;
    send(2, 2, 2, 0, 0, 0);
    b = 0;
    while (n_starts < s0 + 3 && b < 200) begin
      tick();
      b++;
    end
    chk("rst_test_third_start", n_starts, s0 + 3);
    chk("wait_core_start", int'(core_start), 1);
    chk("wait_tiles_issued", int'(tiles_issued), 2);
    d0 = n_done;
    rst = 1'b1;
    tick();
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_core_start", int'(core_start), 0);
    chk("midrst_cmd_ready", int'(cmd_ready), 1);
    rst = 1'b0;
    repeat (10) tick();
    chk("midrst_no_done", n_done, d0);

    // Normal command after the abort
    lat = 3;
    s0 = n_starts;
    push_s(0, 64, 128, 0);
    push_d(1, 1'b0);
    send(1, 1, 1, 0, 64, 128);
    wait_done(d0 + 1, "post_rst_done_seen");
    chk("post_rst_starts", n_starts, s0 + 1);

    repeat (3) tick();
    chk("start_queue_empty", sq.size(), 0);
    chk("done_queue_empty", dq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
